// File: rtl/ex_muldiv_pkg.sv
// Shared opcode classes, funct3/funct7 codes and EX FSM encodings for ex_muldiv.
package ex_muldiv_pkg;

    localparam int unsigned ALUOP_W  = 8;
    localparam int unsigned ALUFUN_W = 3;
    localparam int unsigned FUNCT7_W = 7;

    typedef logic [ALUOP_W-1:0]  AluOpBus;
    typedef logic [ALUFUN_W-1:0] AluFunBus;

    // Instruction classes (RV32 major opcodes)
    localparam AluOpBus EXE_NOP   = 8'h00;
    localparam AluOpBus EXE_ORI   = 8'h13;
    localparam AluOpBus EXE_OR    = 8'h33;
    localparam AluOpBus EXE_LUI   = 8'h37;
    localparam AluOpBus EXE_AUIPC = 8'h17;

    // Base integer funct3
    localparam AluFunBus FUN_ADD  = 3'd0;
    localparam AluFunBus FUN_SLL  = 3'd1;
    localparam AluFunBus FUN_SLT  = 3'd2;
    localparam AluFunBus FUN_SLTU = 3'd3;
    localparam AluFunBus FUN_XOR  = 3'd4;
    localparam AluFunBus FUN_SR   = 3'd5;
    localparam AluFunBus FUN_OR   = 3'd6;
    localparam AluFunBus FUN_AND  = 3'd7;

    // M extension funct3
    localparam AluFunBus FUN_MUL    = 3'd0;
    localparam AluFunBus FUN_MULH   = 3'd1;
    localparam AluFunBus FUN_MULHSU = 3'd2;
    localparam AluFunBus FUN_MULHU  = 3'd3;
    localparam AluFunBus FUN_DIV    = 3'd4;
    localparam AluFunBus FUN_DIVU   = 3'd5;
    localparam AluFunBus FUN_REM    = 3'd6;
    localparam AluFunBus FUN_REMU   = 3'd7;

    localparam logic [FUNCT7_W-1:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    // Operand A is treated as two's complement
    function automatic logic fun_a_signed(input AluFunBus f);
        return (f == FUN_MULH) || (f == FUN_MULHSU) || (f == FUN_DIV) || (f == FUN_REM);
    endfunction

    // Operand B is treated as two's complement
    function automatic logic fun_b_signed(input AluFunBus f);
        return (f == FUN_MULH) || (f == FUN_DIV) || (f == FUN_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, with sign fix-up
// applied on the final step so the result register only ever holds a finished value.
module ex_muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  AluFunBus        i_fun,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_busy,
    output logic            o_done_c,
    output logic            o_special_c,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opb;
    AluFunBus         r_fun;
    logic             r_neg;
    logic [XLEN-1:0]  r_result;

    logic              w_a_neg, w_b_neg, w_neg, w_div_zero, w_ovf;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
    logic [XLEN:0]     w_sum, w_rsh;
    logic [XLEN-1:0]   w_diff, w_hi_n, w_lo_n, w_quo, w_rem, w_final;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    // Operand magnitudes, result sign and the divide corner cases at issue
    always_comb begin
        w_a_neg    = fun_a_signed(i_fun) && i_op_a[XLEN-1];
        w_b_neg    = fun_b_signed(i_fun) && i_op_b[XLEN-1];
        w_a_mag    = w_a_neg ? -i_op_a : i_op_a;
        w_b_mag    = w_b_neg ? -i_op_b : i_op_b;
        w_neg      = (i_fun[2] && i_fun[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = i_fun[2] && (i_op_b == '0);
        w_ovf      = ((i_fun == FUN_DIV) || (i_fun == FUN_REM)) &&
                     (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_op_b);
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = i_fun[1] ? i_op_a : '1;
        end else if (w_ovf) begin
            w_special_res = i_fun[1] ? '0 : i_op_a;
        end
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        w_sum  = '0;
        w_rsh  = '0;
        w_diff = '0;
        w_qbit = 1'b0;
        w_hi_n = r_hi;
        w_lo_n = r_lo;
        if (!r_fun[2]) begin
            w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
            w_hi_n = w_sum[XLEN:1];
            w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
        end else begin
            w_rsh  = {r_hi, r_lo[XLEN-1]};
            w_diff = XLEN'(w_rsh - {1'b0, r_opb});
            w_qbit = (w_rsh >= {1'b0, r_opb});
            w_hi_n = w_qbit ? w_diff : w_rsh[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], w_qbit};
        end
    end

    // Sign fix-up and result selection for the last step
    always_comb begin
        w_prod     = {w_hi_n, w_lo_n};
        w_prod_fix = r_neg ? -w_prod : w_prod;
        w_quo      = r_neg ? -w_lo_n : w_lo_n;
        w_rem      = r_neg ? -w_hi_n : w_hi_n;
        case (r_fun)
            FUN_MUL:                         w_final = w_prod_fix[XLEN-1:0];
            FUN_MULH, FUN_MULHSU, FUN_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            FUN_DIV, FUN_DIVU:               w_final = w_quo;
            default:                         w_final = w_rem;
        endcase
    end

    // Iteration state: load on start, step while busy, abort on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_fun    <= FUN_MUL;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            if (w_div_zero || w_ovf) begin
                r_busy   <= 1'b0;
                r_result <= w_special_res;
            end else begin
                r_busy <= 1'b1;
                r_cnt  <= CNT_W'(XLEN - 1);
                r_fun  <= i_fun;
                r_neg  <= w_neg;
                r_hi   <= '0;
                r_lo   <= i_fun[2] ? w_a_mag : w_b_mag;
                r_opb  <= i_fun[2] ? w_b_mag : w_a_mag;
            end
        end else if (r_busy) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                r_busy   <= 1'b0;
                r_result <= w_final;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done_c    = r_busy && (r_cnt == '0);
    assign o_special_c = w_div_zero || w_ovf;
    assign o_result    = r_result;

endmodule

// File: rtl/ex_muldiv.sv
// RV32/64 execute stage: single-cycle ALU with N-channel bypass, plus an iterative
// M-extension unit that stalls the pipeline. The M unit exists only when EX_MULDIV_EN
// is defined; otherwise M ops retire as non-writing bubbles and clk is unused.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  AluOpBus                   aluop_i,
    input  AluFunBus                  alufun_i,
    input  logic [XLEN-1:0]           reg1_i,
    input  logic [XLEN-1:0]           reg2_i,
    input  logic                      reg1_re,
    input  logic                      reg2_re,
    input  logic [REG_AW-1:0]         reg1_i_addr,
    input  logic [REG_AW-1:0]         reg2_i_addr,
    input  logic [XLEN-1:0]           imm_i,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [REG_AW-1:0]         wd_i,
    input  logic                      wreg_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    output logic [REG_AW-1:0]         wd_o,
    output logic                      wreg_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic                      ex_stall
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_op1, w_op2, w_b, w_alu, w_wdata;
    logic [6:0]      w_funct7;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_r, w_is_m, w_alu_ok, w_wreg, w_stall;

    // Bypass: scan oldest to youngest so the lowest-index match wins
    always_comb begin
        w_op1 = reg1_i;
        w_op2 = reg2_i;
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_we_i[i] && reg1_re && (reg1_i_addr != '0) &&
                (fwd_wd_i[i*REG_AW +: REG_AW] == reg1_i_addr)) begin
                w_op1 = fwd_data_i[i*XLEN +: XLEN];
            end
            if (fwd_we_i[i] && reg2_re && (reg2_i_addr != '0) &&
                (fwd_wd_i[i*REG_AW +: REG_AW] == reg2_i_addr)) begin
                w_op2 = fwd_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // Single-cycle integer ALU
    always_comb begin
        w_funct7 = imm_i[11:5];
        w_is_r   = (aluop_i == EXE_OR);
        w_is_m   = w_is_r && (w_funct7 == FUNCT7_MULDIV);
        w_b      = w_is_r ? w_op2 : imm_i;
        w_shamt  = w_b[SHW-1:0];
        w_alu    = '0;
        w_alu_ok = 1'b1;
        case (aluop_i)
            EXE_ORI, EXE_OR: begin
                case (alufun_i)
                    FUN_ADD:  w_alu = (w_is_r && w_funct7[5]) ? (w_op1 - w_b) : (w_op1 + w_b);
                    FUN_SLL:  w_alu = w_op1 << w_shamt;
                    FUN_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_b))};
                    FUN_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_b)};
                    FUN_XOR:  w_alu = w_op1 ^ w_b;
                    FUN_SR:   w_alu = w_funct7[5] ? XLEN'($signed(w_op1) >>> w_shamt)
                                                  : (w_op1 >> w_shamt);
                    FUN_OR:   w_alu = w_op1 | w_b;
                    default:  w_alu = w_op1 & w_b;
                endcase
            end
            EXE_LUI:   w_alu = imm_i;
            EXE_AUIPC: w_alu = pc_i + imm_i;
            default: begin
                w_alu    = '0;
                w_alu_ok = 1'b0;
            end
        endcase
    end

`ifdef EX_MULDIV_EN
    ex_state_e       r_state, w_state_nxt;
    logic            w_start, w_iter_busy, w_iter_done, w_iter_special;
    logic [XLEN-1:0] w_iter_result;
    logic            w_unused_ok;

    assign w_unused_ok = w_iter_busy;

    ex_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv_iter (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_flush     (flush_i),
        .i_fun       (alufun_i),
        .i_op_a      (w_op1),
        .i_op_b      (w_op2),
        .o_busy      (w_iter_busy),
        .o_done_c    (w_iter_done),
        .o_special_c (w_iter_special),
        .o_result    (w_iter_result)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, issue strobe and stage result selection
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stall     = 1'b0;
        w_wdata     = w_alu;
        w_wreg      = wreg_i && w_alu_ok;
        case (r_state)
            EX_IDLE: begin
                if (w_is_m) begin
                    w_wdata = '0;
                    w_wreg  = 1'b0;
                    if (!flush_i) begin
                        w_start     = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = w_iter_special ? EX_DONE : EX_BUSY;
                    end
                end
            end
            EX_BUSY: begin
                w_wdata = '0;
                w_wreg  = 1'b0;
                w_stall = 1'b1;
                if (w_iter_done) begin
                    w_state_nxt = EX_DONE;
                end
            end
            EX_DONE: begin
                w_wdata = w_iter_result;
                w_wreg  = wreg_i;
                if (!hold_i) begin
                    w_state_nxt = EX_IDLE;
                end
            end
            default: w_state_nxt = EX_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = EX_IDLE;
            w_stall     = 1'b0;
        end
    end
`else
    logic w_unused_ok;

    assign w_unused_ok = clk ^ hold_i;

    // M ops retire as non-writing bubbles
    always_comb begin
        w_stall = 1'b0;
        w_wdata = w_is_m ? '0 : w_alu;
        w_wreg  = wreg_i && w_alu_ok && !w_is_m;
    end
`endif

    assign wd_o     = rst ? '0 : wd_i;
    assign wdata_o  = rst ? '0 : w_wdata;
    assign wreg_o   = !rst && !flush_i && w_wreg;
    assign ex_stall = !rst && w_stall;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: forwarding, ALU corner cases and, when EX_MULDIV_EN is
// defined, M-op latency, divide corner cases, flush, hold and mid-operation reset.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_FWD = 2;
    localparam int unsigned REG_AW  = 5;
    localparam logic [31:0] IMM_M   = 32'h0000_0020;

    logic                      clk = 1'b0;
    logic                      rst;
    AluOpBus                   aluop_i;
    AluFunBus                  alufun_i;
    logic [XLEN-1:0]           reg1_i, reg2_i, imm_i, pc_i;
    logic                      reg1_re, reg2_re;
    logic [REG_AW-1:0]         reg1_i_addr, reg2_i_addr, wd_i;
    logic                      wreg_i;
    logic [NUM_FWD-1:0]        fwd_we_i;
    logic [NUM_FWD*REG_AW-1:0] fwd_wd_i;
    logic [NUM_FWD*XLEN-1:0]   fwd_data_i;
    logic                      hold_i, flush_i;
    logic [REG_AW-1:0]         wd_o;
    logic                      wreg_o;
    logic [XLEN-1:0]           wdata_o;
    logic                      ex_stall;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .alufun_i    (alufun_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .reg1_re     (reg1_re),
        .reg2_re     (reg2_re),
        .reg1_i_addr (reg1_i_addr),
        .reg2_i_addr (reg2_i_addr),
        .imm_i       (imm_i),
        .pc_i        (pc_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .fwd_we_i    (fwd_we_i),
        .fwd_wd_i    (fwd_wd_i),
        .fwd_data_i  (fwd_data_i),
        .hold_i      (hold_i),
        .flush_i     (flush_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .ex_stall    (ex_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input AluOpBus op, input AluFunBus fun, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc);
        aluop_i     = op;
        alufun_i    = fun;
        reg1_i      = a;
        reg2_i      = b;
        imm_i       = imm;
        pc_i        = pc;
        reg1_re     = 1'b1;
        reg2_re     = 1'b1;
        reg1_i_addr = 5'd1;
        reg2_i_addr = 5'd2;
        wd_i        = 5'd9;
        wreg_i      = 1'b1;
    endtask

    task automatic alu_vec(input string tag, input AluOpBus op, input AluFunBus fun,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [31:0] exp, input logic exp_we);
        next_cyc();
        drive_op(op, fun, a, b, imm, pc);
        @(negedge clk);
        chk(tag, 64'(wdata_o), 64'(exp));
        chk({tag, "_wreg"}, 64'(wreg_o), 64'(exp_we));
    endtask

    // Counts consecutive stalled cycles starting at the current sample point
    task automatic wait_stall(output int n);
        n = 0;
        while (ex_stall && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic m_op(input string tag, input AluFunBus fun, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall, input logic [31:0] exp);
        int n;
        next_cyc();
        drive_op(EXE_OR, fun, a, b, IMM_M, 32'h0);
        @(negedge clk);
        chk({tag, "_wreg_stall"}, 64'(wreg_o), 64'd0);
        wait_stall(n);
        chk({tag, "_lat"}, 64'(n), 64'(exp_stall));
        chk(tag, 64'(wdata_o), 64'(exp));
        chk({tag, "_wreg"}, 64'(wreg_o), 64'd1);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        hold_i     = 1'b0;
        flush_i    = 1'b0;
        fwd_we_i   = '0;
        fwd_wd_i   = '0;
        fwd_data_i = '0;
        drive_op(EXE_OR, FUN_ADD, 32'd3, 32'd4, 32'd0, 32'd0);
        wd_i = 5'd7;
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rst_wdata", 64'(wdata_o), 64'd0);
        chk("rst_wreg", 64'(wreg_o), 64'd0);
        chk("rst_wd", 64'(wd_o), 64'd0);
        chk("rst_stall", 64'(ex_stall), 64'd0);
        next_cyc();
        rst = 1'b0;

        // Forwarding priority and suppression
        drive_op(EXE_OR, FUN_ADD, 32'h99, 32'h0, 32'h0, 32'h0);
        wd_i        = 5'd10;
        reg1_i_addr = 5'd5;
        reg2_i_addr = 5'd0;
        fwd_we_i    = 2'b11;
        fwd_wd_i    = {5'd5, 5'd5};
        fwd_data_i  = {32'h22, 32'h11};
        @(negedge clk);
        chk("fwd_ch0", 64'(wdata_o), 64'h11);
        chk("fwd_wd", 64'(wd_o), 64'd10);
        chk("fwd_wreg", 64'(wreg_o), 64'd1);
        next_cyc();
        fwd_we_i = 2'b10;
        @(negedge clk);
        chk("fwd_ch1", 64'(wdata_o), 64'h22);
        next_cyc();
        reg1_re = 1'b0;
        @(negedge clk);
        chk("fwd_re0", 64'(wdata_o), 64'h99);
        next_cyc();
        reg1_re     = 1'b1;
        reg1_i      = 32'h33;
        reg1_i_addr = 5'd0;
        fwd_we_i    = 2'b11;
        fwd_wd_i    = {5'd0, 5'd0};
        @(negedge clk);
        chk("fwd_x0", 64'(wdata_o), 64'h33);
        fwd_we_i = '0;

        // ALU vectors
        alu_vec("slt",   EXE_OR,    FUN_SLT,  32'hFFFFFFFF, 32'd1,    32'h0,   32'h0, 32'd1,        1'b1);
        alu_vec("sltu",  EXE_OR,    FUN_SLTU, 32'hFFFFFFFF, 32'd1,    32'h0,   32'h0, 32'd0,        1'b1);
        alu_vec("srai",  EXE_ORI,   FUN_SR,   32'h80000000, 32'd0,    32'h404, 32'h0, 32'hF8000000, 1'b1);
        alu_vec("srli",  EXE_ORI,   FUN_SR,   32'h80000000, 32'd0,    32'h004, 32'h0, 32'h08000000, 1'b1);
        alu_vec("sra_r", EXE_OR,    FUN_SR,   32'h80000000, 32'h24,   32'h400, 32'h0, 32'hF8000000, 1'b1);
        alu_vec("sub",   EXE_OR,    FUN_ADD,  32'd10,       32'd3,    32'h400, 32'h0, 32'd7,        1'b1);
        alu_vec("addi",  EXE_ORI,   FUN_ADD,  32'd10,       32'd3,    32'h400, 32'h0, 32'h40A,      1'b1);
        alu_vec("sll",   EXE_OR,    FUN_SLL,  32'd1,        32'h21,   32'h0,   32'h0, 32'd2,        1'b1);
        alu_vec("xori",  EXE_ORI,   FUN_XOR,  32'h0000F0F0, 32'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFF0F0F, 1'b1);
        alu_vec("and",   EXE_OR,    FUN_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 32'h0F000F00, 1'b1);
        alu_vec("or",    EXE_OR,    FUN_OR,   32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 32'hFFF0FFF0, 1'b1);
        alu_vec("lui",   EXE_LUI,   FUN_ADD,  32'd0,        32'd0, 32'h12345000, 32'h0, 32'h12345000, 1'b1);
        alu_vec("auipc", EXE_AUIPC, FUN_ADD,  32'd0,        32'd0, 32'h2000, 32'h1000, 32'h3000,   1'b1);
        alu_vec("unk",   8'hFF,     FUN_ADD,  32'd5,        32'd6,    32'h0,   32'h0, 32'd0,        1'b0);

`ifdef EX_MULDIV_EN
        m_op("mul",    FUN_MUL,    32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB);
        m_op("mulhu",  FUN_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
        m_op("mulh",   FUN_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000);
        m_op("mulhsu", FUN_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF);
        m_op("div",    FUN_DIV,    32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD);
        m_op("rem",    FUN_REM,    32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF);
        m_op("remu",   FUN_REMU,   32'd13,       32'd5,        33, 32'd3);
        m_op("div0",   FUN_DIV,    32'd5,        32'd0,        1,  32'hFFFFFFFF);
        m_op("removf", FUN_REM,    32'h80000000, 32'hFFFFFFFF, 1,  32'd0);

        // Flush on the tenth BUSY cycle
        next_cyc();
        drive_op(EXE_OR, FUN_MUL, 32'd7, 32'hFFFFFFFD, IMM_M, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(ex_stall), 64'd0);
        chk("flush_wreg", 64'(wreg_o), 64'd0);
        next_cyc();
        flush_i = 1'b0;
        drive_op(EXE_OR, FUN_ADD, 32'd2, 32'd3, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_flush_add", 64'(wdata_o), 64'd5);
        chk("post_flush_wreg", 64'(wreg_o), 64'd1);
        chk("post_flush_stall", 64'(ex_stall), 64'd0);

        // Hold in DONE keeps the result stable
        next_cyc();
        drive_op(EXE_OR, FUN_DIVU, 32'd13, 32'd2, IMM_M, 32'h0);
        hold_i = 1'b1;
        @(negedge clk);
        wait_stall(n);
        chk("divu_lat", 64'(n), 64'd33);
        for (int k = 0; k < 3; k++) begin
            chk("hold_wdata", 64'(wdata_o), 64'd6);
            chk("hold_stall", 64'(ex_stall), 64'd0);
            if (k < 2) @(negedge clk);
        end
        next_cyc();
        hold_i = 1'b0;
        @(negedge clk);
        chk("hold_release", 64'(wdata_o), 64'd6);
        chk("hold_release_wreg", 64'(wreg_o), 64'd1);

        // Reset in the middle of BUSY
        next_cyc();
        drive_op(EXE_OR, FUN_MUL, 32'd7, 32'hFFFFFFFD, IMM_M, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_wdata", 64'(wdata_o), 64'd0);
        chk("mrst_wreg", 64'(wreg_o), 64'd0);
        chk("mrst_wd", 64'(wd_o), 64'd0);
        chk("mrst_stall", 64'(ex_stall), 64'd0);
        next_cyc();
        rst = 1'b0;
        drive_op(EXE_OR, FUN_ADD, 32'd2, 32'd3, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_add", 64'(wdata_o), 64'd5);
        chk("post_rst_stall", 64'(ex_stall), 64'd0);
`else
        // Without the M unit an M op is a non-writing, non-stalling bubble
        next_cyc();
        drive_op(EXE_OR, FUN_MUL, 32'd7, 32'hFFFFFFFD, IMM_M, 32'h0);
        @(negedge clk);
        chk("m_off_stall", 64'(ex_stall), 64'd0);
        chk("m_off_wdata", 64'(wdata_o), 64'd0);
        chk("m_off_wreg", 64'(wreg_o), 64'd0);
`endif

        // Flush kills an ALU op's write-back
        next_cyc();
        drive_op(EXE_OR, FUN_ADD, 32'd2, 32'd3, 32'h0, 32'h0);
        flush_i = 1'b1;
        @(negedge clk);
        chk("alu_flush_wreg", 64'(wreg_o), 64'd0);
        next_cyc();
        flush_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised execute stage for the RV32 pipeline, placed between the id_ex and ex_mem latches. It computes every OP-IMM, OP, LUI and AUIPC result in the same cycle, with correct SLT/SLTU/SRA semantics. It forwards operands from N configurable bypass channels. It adds an iterative multiply/divide unit for the M extension, which stalls the pipeline through `ex_stall` until the result is ready.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- NUM_FWD, 2, bypass channel count; channel 0 = youngest (ex_mem), highest priority
- REG_AW, 5, register address width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset (`RstEnable`); one clock domain only
- aluop_i  in  `AluOpBus`  class: EXE_ORI (OP-IMM), EXE_OR (OP), EXE_LUI, EXE_AUIPC
- alufun_i  in  `AluFunBus`  funct3
- reg1_i, reg2_i  in  XLEN  regfile operands
- reg1_re, reg2_re  in  1  operand read enables
- reg1_i_addr, reg2_i_addr  in  REG_AW  operand addresses
- imm_i  in  XLEN  sign-extended immediate; for EXE_OR, imm_i[11:5] = funct7
- pc_i  in  XLEN  instruction PC
- wd_i  in  REG_AW; wreg_i  in  1  destination and write enable
- fwd_we_i  in  NUM_FWD  per-channel write enable
- fwd_wd_i  in  NUM_FWD*REG_AW  per-channel destination, packed
- fwd_data_i  in  NUM_FWD*XLEN  per-channel data, packed
- hold_i  in  1  downstream stall; the current instruction must not leave EX
- flush_i  in  1  branch or exception kill of the instruction in EX
- wd_o  out  REG_AW; wreg_o  out  1; wdata_o  out  XLEN  write-back triple
- ex_stall  out  1  EX cannot complete this cycle; upstream holds id_ex

## Operation
- Forwarding, per operand: the lowest-index channel with we=1, wd==addr and re=1 supplies the operand. If no channel matches, the regfile value is used. An address of 0 never forwards.
- ALU ops:
  - ADD/SUB: SUB when EXE_OR and funct7[5]=1.
  - SLT/SLTU: result 1/0.
  - Shifts use the low log2(XLEN) bits of the shift amount.
  - SRA when funct7[5]=1, otherwise SRL.
  - LUI = imm.
  - AUIPC = pc+imm.
  - An unknown aluop gives wdata 0 and wreg_o 0.
- An M op is EXE_OR with funct7==0000001. funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
- FSM states IDLE, BUSY, DONE:
  - IDLE with an M op and no flush: latch the forwarded operands, go to BUSY, ex_stall=1.
  - Divide by zero: quotient all-ones, remainder = dividend. Go straight to DONE with no BUSY cycles.
  - Signed overflow (min / -1): quotient = dividend, remainder 0. Go straight to DONE.
  - BUSY: one radix-2 step per cycle for XLEN cycles (counter XLEN-1..0), ex_stall=1, then go to DONE.
  - DONE: ex_stall=0, wdata_o = latched result. If hold_i=1, stay in DONE; otherwise go to IDLE.
- Multiply: shift-add on XLEN+1-bit sign-adjusted magnitudes. Signed divide: unsigned restoring divide with sign fix-up at DONE.
- While ex_stall=1, wreg_o=0, so no bubble writes back.
- flush_i in any state: go to IDLE next cycle, ex_stall=0 in that same cycle, result discarded.
- wd_o always equals wd_i.

## Timing
- Reset: FSM IDLE, counter 0, result register 0. wdata_o=0, wreg_o=0, wd_o=0 and ex_stall=0 while rst=1.
- ALU ops: combinational, zero added latency.
- M latency: 1 issue cycle + XLEN BUSY cycles, then result valid in DONE. ex_stall is high for XLEN+1 cycles (33 at XLEN=32).
- Divide-by-zero and overflow: ex_stall high for exactly 1 cycle.
- Back-to-back M ops: DONE→IDLE→issue, with no lost cycle beyond the IDLE issue cycle.
- Reset or flush during BUSY: aborts within one cycle. No partial result is ever presented.

## Configuration
- Macro `EX_MULDIV_EN`.
- Defined: behaviour exactly as above.
- Undefined:
  - The FSM and the muldiv_iter instance are removed.
  - M ops produce wdata_o=0, wreg_o=0, ex_stall=0.
  - clk is unused.

## Structure
- defines.v holds:
  - `AluOpBus` and `AluFunBus`
  - EXE_* and FUN_* codes
  - new FUN_MUL..FUN_REMU funct3 codes and the FUNCT7_MULDIV constant
  - FSM state encodings EX_IDLE, EX_BUSY, EX_DONE
- One sub-module, muldiv_iter:
  - Contains the counter, shift registers and sign fix-up.
  - Handshake: start/flush in, busy/done/result out.
  - The FSM sits in ex_muldiv.

## Test plan
- Forwarding priority: channel 0 and channel 1 both target x5, with values 0x11 and 0x22, ADD x5+x0 → 0x11. Destination x0 → no forward.
- SLT -1 vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0. SRAI 0x80000000 by 4 → 0xF8000000.
- MUL 7×(-3) → 0xFFFFFFEB after ex_stall=1 for 33 cycles. MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
- DIV 5/0 → 0xFFFFFFFF. REM 0x80000000 / -1 → 0. Each has a 1-cycle stall.
- flush_i on BUSY cycle 10 → ex_stall=0 in that cycle, IDLE next cycle, wreg_o=0. The following ADD completes normally.
- hold_i=1 for 3 cycles in DONE → wdata_o stable at 6 (DIVU 13/2) throughout. Reset asserted mid-BUSY → all outputs 0.
